irq_collect: RTL

IRQ_COLLECT -- requirements
Module: irq_collect

---
 rtl/irq_collect.sv | 104 ++++++++++
 1 files changed

// File: rtl/irq_collect.sv
// Interrupt request collector: synchronizes eight async request lines, latches rising
// edges as pending events, and offers one encoded ID at a time under a valid/ack handshake.
module irq_collect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  output logic [7:0] pend,
  input  logic [2:0] enc_idx,
  output logic       irq_valid,
  output logic [2:0] irq_id,
  input  logic       irq_ack,
  output logic [7:0] ovf,
  input  logic       ovf_clr
);

  typedef enum logic {IDLE, OFFER} state_t;

  logic [SYNC_STAGES-1:0][7:0] sync_reg;
  logic [7:0] prev_reg;
  logic [7:0] raw_reg;
  logic [7:0] ovf_reg;
  state_t     state_reg;
  logic       irq_valid_reg;
  logic [2:0] irq_id_reg;

  logic [7:0] sync_last;
  logic [7:0] edge_vec;
  logic [7:0] clr_vec;
  logic [7:0] raw_next;
  logic [7:0] ovf_set;
  logic [7:0] ovf_next;
  logic       ack_fire;

  assign sync_last = sync_reg[SYNC_STAGES-1];
  assign edge_vec  = sync_last & ~prev_reg;
  assign ack_fire  = (state_reg == OFFER) && irq_ack;

  // A new edge on the bit being acknowledged re-arms it instead of counting as lost.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      assign clr_vec[gi]  = ack_fire && (irq_id_reg == 3'(gi));
      assign raw_next[gi] = (raw_reg[gi] & ~clr_vec[gi]) | edge_vec[gi];
      assign ovf_set[gi]  = edge_vec[gi] & raw_reg[gi] & ~clr_vec[gi];
    end
  endgenerate

  assign ovf_next = (ovf_clr ? 8'h00 : ovf_reg) | ovf_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      prev_reg <= 8'h00;
      raw_reg  <= 8'h00;
      ovf_reg  <= 8'h00;
    end else begin
      sync_reg[0] <= req;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_reg[s] <= sync_reg[s-1];
      end
      prev_reg <= sync_last;
      raw_reg  <= raw_next;
      ovf_reg  <= ovf_next;
    end
  end

  // The offered ID is captured on entry to OFFER and frozen until acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      irq_valid_reg <= 1'b0;
      irq_id_reg    <= 3'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pend != 8'h00) begin
            state_reg     <= OFFER;
            irq_valid_reg <= 1'b1;
            irq_id_reg    <= enc_idx;
          end
        end
        OFFER: begin
          if (irq_ack) begin
            state_reg     <= IDLE;
            irq_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          irq_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign pend      = raw_reg & mask;
  assign irq_valid = irq_valid_reg;
  assign irq_id    = irq_id_reg;
  assign ovf       = ovf_reg;

endmodule
